// File: rtl/riscv_imm_pkg.sv
// Shared types, opcode constants, immediate ranges and packing helpers
// for the RV64 immediate encoder.
package riscv_imm_pkg;

  typedef enum logic [2:0] {
    IT_I  = 3'b000,
    IT_S  = 3'b001,
    IT_SB = 3'b010,
    IT_UJ = 3'b011,
    IT_U  = 3'b100
  } instr_type_e;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [2:0] F3_ADDI    = 3'b000;

  localparam logic signed [63:0] I_MIN  = -64'sd2048;
  localparam logic signed [63:0] I_MAX  =  64'sd2047;
  localparam logic signed [63:0] S_MIN  = -64'sd2048;
  localparam logic signed [63:0] S_MAX  =  64'sd2047;
  localparam logic signed [63:0] SB_MIN = -64'sd4096;
  localparam logic signed [63:0] SB_MAX =  64'sd4094;
  localparam logic signed [63:0] UJ_MIN = -64'sd1048576;
  localparam logic signed [63:0] UJ_MAX =  64'sd1048574;
  localparam logic signed [63:0] U_MIN  = -64'sd524288;
  localparam logic signed [63:0] U_MAX  =  64'sd524287;

  // LUI+ADDI window; upper bound leaves room for the imm[11] carry into hi
  localparam logic signed [63:0] EXP_MIN = -64'sd2147483648;
  localparam logic signed [63:0] EXP_MAX =  64'sd2147481599;

  // Scatter immediate bits into the template's immediate fields.
  function automatic logic [31:0] pack_imm(input logic [2:0] ty,
                                           input logic [31:0] t,
                                           input logic [63:0] imm);
    logic [31:0] w;
    w = t;
    case (ty)
      IT_I:  w = {imm[11:0], t[19:0]};
      IT_S:  w = {imm[11:5], t[24:12], imm[4:0], t[6:0]};
      IT_SB: w = {imm[12], imm[10:5], t[24:12], imm[4:1], imm[11], t[6:0]};
      IT_UJ: w = {imm[20], imm[10:1], imm[11], imm[19:12], t[11:0]};
      IT_U:  w = {imm[19:0], t[11:0]};
      default: w = t;
    endcase
    return w;
  endfunction

  // Template with the immediate fields of the given type cleared.
  function automatic logic [31:0] mask_imm(input logic [2:0] ty,
                                           input logic [31:0] t);
    logic [31:0] w;
    w = t;
    case (ty)
      IT_I:          w = {12'b0, t[19:0]};
      IT_S, IT_SB:   w = {7'b0, t[24:12], 5'b0, t[6:0]};
      IT_UJ, IT_U:   w = {20'b0, t[11:0]};
      default:       w = t;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/imm_range_check.sv
// Combinational legality check of a 64-bit signed immediate for a given
// instruction type. Illegal type codes report out of range.
module imm_range_check
  import riscv_imm_pkg::*;
(
  input  logic [2:0]  i_type,
  input  logic [63:0] i_imm,
  output logic        o_in_range,
  output logic        o_misaligned
);

  logic signed [63:0] w_imm;

  // Compare the full signed value against the per-type window
  always_comb begin
    w_imm        = $signed(i_imm);
    o_in_range   = 1'b0;
    o_misaligned = 1'b0;
    case (i_type)
      IT_I:  o_in_range = (w_imm >= I_MIN)  && (w_imm <= I_MAX);
      IT_S:  o_in_range = (w_imm >= S_MIN)  && (w_imm <= S_MAX);
      IT_SB: begin
        o_in_range   = (w_imm >= SB_MIN) && (w_imm <= SB_MAX);
        o_misaligned = i_imm[0];
      end
      IT_UJ: begin
        o_in_range   = (w_imm >= UJ_MIN) && (w_imm <= UJ_MAX);
        o_misaligned = i_imm[0];
      end
      IT_U:  o_in_range = (w_imm >= U_MIN)  && (w_imm <= U_MAX);
      default: begin
        o_in_range   = 1'b0;
        o_misaligned = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/imm_encoder.sv
// Streaming immediate encoder: packs a 64-bit immediate into an RV64
// instruction template, optionally splitting wide ADDI into LUI+ADDI.
//
// state   | meaning
// IDLE    | no output word held, ready for a request
// ONE     | presenting a single word (or final ADDI of a pair, or an error)
// PAIR_HI | presenting the LUI of a pair, ADDI waiting in r_pend
module imm_encoder
  import riscv_imm_pkg::*;
#(
  parameter bit EXPAND_EN = 1'b1
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_in_valid,
  output logic        o_in_ready,
  input  logic [31:0] i_in_instr,
  input  logic [2:0]  i_in_type,
  input  logic [63:0] i_in_imm,
  output logic        o_out_valid,
  input  logic        i_out_ready,
  output logic [31:0] o_out_instr,
  output logic        o_out_err,
  output logic        o_out_last
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ONE     = 2'd1,
    ST_PAIR_HI = 2'd2
  } state_e;

  state_e      r_state, w_state_nxt;
  logic [31:0] r_out_instr, r_pend;
  logic        r_out_err, r_out_last;

  logic        w_in_range, w_misaligned;
  logic        w_is_addi, w_exp_range, w_expand, w_err;
  logic [4:0]  w_rd;
  logic [19:0] w_hi;
  logic [31:0] w_lui, w_addi, w_word;
  logic        w_load_new, w_load_pend;

  imm_range_check u_range (
    .i_type       (i_in_type),
    .i_imm        (i_in_imm),
    .o_in_range   (w_in_range),
    .o_misaligned (w_misaligned)
  );

  // Decode expansion eligibility and build the candidate output words
  always_comb begin
    w_rd        = i_in_instr[11:7];
    w_is_addi   = (i_in_type == IT_I) && (i_in_instr[6:0] == OPC_OP_IMM) &&
                  (i_in_instr[14:12] == F3_ADDI) && (w_rd != 5'd0);
    w_exp_range = ($signed(i_in_imm) >= EXP_MIN) && ($signed(i_in_imm) <= EXP_MAX);
    w_expand    = EXPAND_EN && w_is_addi && !w_in_range && w_exp_range;
    w_err       = !w_expand && (!w_in_range || w_misaligned);
    w_hi        = i_in_imm[31:12] + {19'b0, i_in_imm[11]};
    w_lui       = {w_hi, w_rd, OPC_LUI};
    w_addi      = {i_in_imm[11:0], w_rd, F3_ADDI, w_rd, OPC_OP_IMM};
    if (w_expand)
      w_word = w_lui;
    else if (w_err)
      w_word = mask_imm(i_in_type, i_in_instr);
    else
      w_word = pack_imm(i_in_type, i_in_instr, i_in_imm);
  end

  // State register
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset)
      r_state <= ST_IDLE;
    else
      r_state <= w_state_nxt;
  end

  // Next state, handshake and load strobes
  always_comb begin
    w_state_nxt = r_state;
    o_in_ready  = 1'b0;
    o_out_valid = 1'b0;
    w_load_new  = 1'b0;
    w_load_pend = 1'b0;
    case (r_state)
      ST_IDLE: begin
        o_in_ready = 1'b1;
        if (i_in_valid) begin
          w_load_new  = 1'b1;
          w_state_nxt = w_expand ? ST_PAIR_HI : ST_ONE;
        end
      end
      ST_ONE: begin
        o_out_valid = 1'b1;
        if (i_out_ready) begin
          o_in_ready = 1'b1;
          if (i_in_valid) begin
            w_load_new  = 1'b1;
            w_state_nxt = w_expand ? ST_PAIR_HI : ST_ONE;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      ST_PAIR_HI: begin
        o_out_valid = 1'b1;
        if (i_out_ready) begin
          w_load_pend = 1'b1;
          w_state_nxt = ST_ONE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Output and pending-ADDI registers; hold while the consumer stalls
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_out_instr <= 32'd0;
      r_out_err   <= 1'b0;
      r_out_last  <= 1'b0;
      r_pend      <= 32'd0;
    end else if (w_load_new) begin
      r_out_instr <= w_word;
      r_out_err   <= w_err;
      r_out_last  <= !w_expand;
      if (w_expand)
        r_pend <= w_addi;
    end else if (w_load_pend) begin
      r_out_instr <= r_pend;
      r_out_err   <= 1'b0;
      r_out_last  <= 1'b1;
    end
  end

  assign o_out_instr = r_out_instr;
  assign o_out_err   = r_out_err;
  assign o_out_last  = r_out_last;

endmodule
